// File: rtl/pkt_buffer_writer.sv
// pkt_buffer_writer
// Packet/metadata buffer write controller downstream of the PIFO enqueue stage.
// It admits or drops each whole packet at its first beat. Admitted beats are written
// into a ring-addressed packet memory, and the metadata into a ring-addressed slot memory.
// On the last beat it returns the head beat address and the metadata slot of the packet.
//
// Optional feature: define PKT_BUFFER_WRITER_DROP_CNT_EN to build a 32-bit wrapping
// dropped-packet counter on m_drop_count. Otherwise m_drop_count is tied to 0.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   s_axis_*                   beat stream in (data, keep, last, metadata, wr_en)
//   s_release_valid/_beats     packet reclaimed by the dequeue side, beats it freed
//   m_mem_wr_*                 packet memory write port, data = {tlast, tkeep, tdata}
//   m_meta_wr_*                metadata memory write port
//   m_axis_packet_addr(_valid) head address of a completed packet (one-cycle pulse)
//   m_axis_meta_addr(_valid)   metadata slot of a completed packet (same cycle)
//   m_beat_count/m_meta_count  occupancy counters
//   m_data/meta_almost_full    overflow hints for the enqueue stage
//   m_drop_count               dropped packets (0 unless the counter is built)
module pkt_buffer_writer #(
    parameter int unsigned DATA_WIDTH      = 256,
    parameter int unsigned SUME_META_WIDTH = 128,
    parameter int unsigned PKT_ADDR_WIDTH  = 11,
    parameter int unsigned META_ADDR_WIDTH = 5,
    parameter int unsigned MAX_PKT_BEATS   = 48
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [DATA_WIDTH-1:0]                 s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]               s_axis_tkeep,
    input  logic                                  s_axis_tlast,
    input  logic [SUME_META_WIDTH-1:0]            s_axis_tuser,
    input  logic                                  s_axis_wr_en,
    input  logic                                  s_release_valid,
    input  logic [PKT_ADDR_WIDTH-1:0]             s_release_beats,
    output logic                                  m_mem_wr_en,
    output logic [PKT_ADDR_WIDTH-1:0]             m_mem_wr_addr,
    output logic [DATA_WIDTH/8+DATA_WIDTH:0]      m_mem_wr_data,
    output logic                                  m_meta_wr_en,
    output logic [META_ADDR_WIDTH-1:0]            m_meta_wr_addr,
    output logic [SUME_META_WIDTH-1:0]            m_meta_wr_data,
    output logic [PKT_ADDR_WIDTH-1:0]             m_axis_packet_addr,
    output logic                                  m_axis_packet_addr_valid,
    output logic [META_ADDR_WIDTH-1:0]            m_axis_meta_addr,
    output logic                                  m_axis_meta_addr_valid,
    output logic [PKT_ADDR_WIDTH:0]               m_beat_count,
    output logic [META_ADDR_WIDTH:0]              m_meta_count,
    output logic                                  m_data_almost_full,
    output logic                                  m_meta_almost_full,
    output logic [31:0]                           m_drop_count
);

    localparam logic [PKT_ADDR_WIDTH:0]  PktDepth  = {1'b1, {PKT_ADDR_WIDTH{1'b0}}};
    localparam logic [META_ADDR_WIDTH:0] MetaDepth = {1'b1, {META_ADDR_WIDTH{1'b0}}};
    localparam logic [PKT_ADDR_WIDTH:0]  MaxBeats  = (PKT_ADDR_WIDTH + 1)'(MAX_PKT_BEATS);

    typedef enum logic [1:0] {StIdle, StWrite, StDrop} state_e;

    state_e                        state_q, state_d;
    logic [PKT_ADDR_WIDTH-1:0]     wr_ptr_q;
    logic [META_ADDR_WIDTH-1:0]    meta_ptr_q;
    logic [PKT_ADDR_WIDTH-1:0]     head_q;
    logic [META_ADDR_WIDTH-1:0]    slot_q;
    logic [PKT_ADDR_WIDTH:0]       beat_count_q;
    logic [META_ADDR_WIDTH:0]      meta_count_q;

    logic                          mem_wr_en_q;
    logic [PKT_ADDR_WIDTH-1:0]     mem_wr_addr_q;
    logic [DATA_WIDTH/8+DATA_WIDTH:0] mem_wr_data_q;
    logic                          meta_wr_en_q;
    logic [META_ADDR_WIDTH-1:0]    meta_wr_addr_q;
    logic [SUME_META_WIDTH-1:0]    meta_wr_data_q;
    logic                          done_q;
    logic [PKT_ADDR_WIDTH-1:0]     done_head_q;
    logic [META_ADDR_WIDTH-1:0]    done_slot_q;

    logic                          can_admit;
    logic                          beat_wr;
    logic                          meta_wr;
    logic                          done;
    logic                          drop_inc;
    logic [PKT_ADDR_WIDTH-1:0]     head_sel;
    logic [META_ADDR_WIDTH-1:0]    slot_sel;
    logic [PKT_ADDR_WIDTH:0]       beat_sum;
    logic [PKT_ADDR_WIDTH:0]       beat_count_d;
    logic [META_ADDR_WIDTH:0]      meta_sum;
    logic [META_ADDR_WIDTH:0]      meta_count_d;
    logic [PKT_ADDR_WIDTH:0]       release_beats;

    // Admission looks only at registered counters; a release this cycle is not yet visible.
    assign can_admit = ((PktDepth - beat_count_q) >= MaxBeats) && (meta_count_q != MetaDepth);

    // A single-beat packet completes from IDLE before head/slot are latched.
    assign head_sel = (state_q == StIdle) ? wr_ptr_q : head_q;
    assign slot_sel = (state_q == StIdle) ? meta_ptr_q : slot_q;

    always_comb begin
        state_d  = state_q;
        beat_wr  = 1'b0;
        meta_wr  = 1'b0;
        done     = 1'b0;
        drop_inc = 1'b0;
        if (s_axis_wr_en) begin
            unique case (state_q)
                StIdle: begin
                    if (can_admit) begin
                        meta_wr = 1'b1;
                        beat_wr = 1'b1;
                        done    = s_axis_tlast;
                        state_d = s_axis_tlast ? StIdle : StWrite;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = s_axis_tlast ? StIdle : StDrop;
                    end
                end
                StWrite: begin
                    beat_wr = 1'b1;
                    if (s_axis_tlast) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end
                end
                StDrop: begin
                    if (s_axis_tlast) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Net counter update with saturation at zero on over-release.
    always_comb begin
        release_beats = {1'b0, s_release_beats};
        beat_sum      = beat_count_q + {{PKT_ADDR_WIDTH{1'b0}}, beat_wr};
        meta_sum      = meta_count_q + {{META_ADDR_WIDTH{1'b0}}, meta_wr};
        beat_count_d  = beat_sum;
        meta_count_d  = meta_sum;
        if (s_release_valid) begin
            beat_count_d = (release_beats > beat_sum) ? '0 : beat_sum - release_beats;
            meta_count_d = (meta_sum == '0) ? '0 : meta_sum - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            meta_ptr_q     <= '0;
            head_q         <= '0;
            slot_q         <= '0;
            beat_count_q   <= '0;
            meta_count_q   <= '0;
            mem_wr_en_q    <= 1'b0;
            mem_wr_addr_q  <= '0;
            mem_wr_data_q  <= '0;
            meta_wr_en_q   <= 1'b0;
            meta_wr_addr_q <= '0;
            meta_wr_data_q <= '0;
            done_q         <= 1'b0;
            done_head_q    <= '0;
            done_slot_q    <= '0;
        end else begin
            state_q      <= state_d;
            beat_count_q <= beat_count_d;
            meta_count_q <= meta_count_d;
            mem_wr_en_q  <= beat_wr;
            meta_wr_en_q <= meta_wr;
            done_q       <= done;
            if (meta_wr) begin
                head_q         <= wr_ptr_q;
                slot_q         <= meta_ptr_q;
                meta_ptr_q     <= meta_ptr_q + 1'b1;
                meta_wr_addr_q <= meta_ptr_q;
                meta_wr_data_q <= s_axis_tuser;
            end
            if (beat_wr) begin
                wr_ptr_q      <= wr_ptr_q + 1'b1;
                mem_wr_addr_q <= wr_ptr_q;
                mem_wr_data_q <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
            end
            if (done) begin
                done_head_q <= head_sel;
                done_slot_q <= slot_sel;
            end
        end
    end

`ifdef PKT_BUFFER_WRITER_DROP_CNT_EN
    logic [31:0] drop_cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop_inc) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end
    assign m_drop_count = drop_cnt_q;
`else
    logic unused_drop_inc;
    assign unused_drop_inc = drop_inc;
    assign m_drop_count    = 32'd0;
`endif

    assign m_mem_wr_en              = mem_wr_en_q;
    assign m_mem_wr_addr            = mem_wr_addr_q;
    assign m_mem_wr_data            = mem_wr_data_q;
    assign m_meta_wr_en             = meta_wr_en_q;
    assign m_meta_wr_addr           = meta_wr_addr_q;
    assign m_meta_wr_data           = meta_wr_data_q;
    assign m_axis_packet_addr       = done_head_q;
    assign m_axis_packet_addr_valid = done_q;
    assign m_axis_meta_addr         = done_slot_q;
    assign m_axis_meta_addr_valid   = done_q;
    assign m_beat_count             = beat_count_q;
    assign m_meta_count             = meta_count_q;
    assign m_data_almost_full       = (PktDepth - beat_count_q) < MaxBeats;
    assign m_meta_almost_full       = (meta_count_q == MetaDepth);

endmodule

// File: tb/tb_pkt_buffer_writer.sv
// Self-checking bench for pkt_buffer_writer: directed test-plan steps followed by
// random packets. Each cycle is compared against a packet-level reference model.
// Set PKT_BUFFER_WRITER_DROP_CNT_EN to match the DUT build.
module tb_pkt_buffer_writer;

    localparam int DW = 256, MW = 128, PAW = 11, MAW = 5, KW = DW / 8;
    localparam int MAXB = 48, PD = 2048, MD = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [DW-1:0] tdata = '0;
    logic [KW-1:0] tkeep = '0;
    logic tlast = 1'b0;
    logic [MW-1:0] tuser = '0;
    logic wr_en = 1'b0;
    logic rel_valid = 1'b0;
    logic [PAW-1:0] rel_beats = '0;

    logic mem_wr_en, meta_wr_en, pkt_valid, meta_valid, data_af, meta_af;
    logic [PAW-1:0] mem_wr_addr, pkt_addr;
    logic [KW+DW:0] mem_wr_data;
    logic [MAW-1:0] meta_wr_addr, meta_addr;
    logic [MW-1:0] meta_wr_data;
    logic [PAW:0] beat_count;
    logic [MAW:0] meta_count;
    logic [31:0] drop_count;

    pkt_buffer_writer dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
        .s_axis_tuser(tuser), .s_axis_wr_en(wr_en),
        .s_release_valid(rel_valid), .s_release_beats(rel_beats),
        .m_mem_wr_en(mem_wr_en), .m_mem_wr_addr(mem_wr_addr), .m_mem_wr_data(mem_wr_data),
        .m_meta_wr_en(meta_wr_en), .m_meta_wr_addr(meta_wr_addr),
        .m_meta_wr_data(meta_wr_data),
        .m_axis_packet_addr(pkt_addr), .m_axis_packet_addr_valid(pkt_valid),
        .m_axis_meta_addr(meta_addr), .m_axis_meta_addr_valid(meta_valid),
        .m_beat_count(beat_count), .m_meta_count(meta_count),
        .m_data_almost_full(data_af), .m_meta_almost_full(meta_af),
        .m_drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: packet-level bookkeeping.
    int m_wptr, m_mptr, m_beats, m_slots, m_head, m_slot;
    int unsigned m_drops;
    bit m_in_pkt, m_admitted;
    bit e_mem_en, e_meta_en, e_pulse;
    int e_mem_addr, e_meta_addr, e_paddr, e_maddr;
    logic [KW+DW:0] e_mem_data;
    logic [MW-1:0] e_meta_data;

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wptr = 0; m_mptr = 0; m_beats = 0; m_slots = 0; m_head = 0; m_slot = 0;
        m_drops = 0; m_in_pkt = 0; m_admitted = 0;
        e_mem_en = 0; e_meta_en = 0; e_pulse = 0;
    endtask

    task automatic check_all();
        chk("mem_wr_en", 300'(mem_wr_en), 300'(e_mem_en));
        if (e_mem_en) begin
            chk("mem_wr_addr", 300'(mem_wr_addr), 300'(e_mem_addr));
            chk("mem_wr_data", 300'(mem_wr_data), 300'(e_mem_data));
        end
        chk("meta_wr_en", 300'(meta_wr_en), 300'(e_meta_en));
        if (e_meta_en) begin
            chk("meta_wr_addr", 300'(meta_wr_addr), 300'(e_meta_addr));
            chk("meta_wr_data", 300'(meta_wr_data), 300'(e_meta_data));
        end
        chk("pkt_valid", 300'(pkt_valid), 300'(e_pulse));
        chk("meta_valid", 300'(meta_valid), 300'(e_pulse));
        if (e_pulse) begin
            chk("pkt_addr", 300'(pkt_addr), 300'(e_paddr));
            chk("meta_addr", 300'(meta_addr), 300'(e_maddr));
        end
        chk("beat_count", 300'(beat_count), 300'(m_beats));
        chk("meta_count", 300'(meta_count), 300'(m_slots));
        chk("data_af", 300'(data_af), 300'((PD - m_beats) < MAXB));
        chk("meta_af", 300'(meta_af), 300'(m_slots == MD));
`ifdef PKT_BUFFER_WRITER_DROP_CNT_EN
        chk("drop_count", 300'(drop_count), 300'(m_drops));
`else
        chk("drop_count", 300'(drop_count), 300'(0));
`endif
    endtask

    // One clock: drive inputs, advance the model, check one unit after the edge.
    task automatic step(input bit we, input bit last, input logic [MW-1:0] u,
                        input bit rv, input int rb);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        int inc_b, inc_s;
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        k = $urandom;
        wr_en = we; tlast = last; tuser = u; tdata = d; tkeep = k;
        rel_valid = rv; rel_beats = PAW'(rb);
        e_mem_en = 0; e_meta_en = 0; e_pulse = 0; inc_b = 0; inc_s = 0;
        if (we) begin
            if (!m_in_pkt) begin
                m_admitted = (PD - m_beats >= MAXB) && (m_slots < MD);
                if (m_admitted) begin
                    m_head = m_wptr; m_slot = m_mptr;
                    e_meta_en = 1; e_meta_addr = m_mptr; e_meta_data = u;
                    m_mptr = (m_mptr + 1) % MD; inc_s = 1;
                end else begin
                    m_drops++;
                end
            end
            if (m_admitted) begin
                e_mem_en = 1; e_mem_addr = m_wptr; e_mem_data = {last, k, d};
                m_wptr = (m_wptr + 1) % PD; inc_b = 1;
                if (last) begin
                    e_pulse = 1; e_paddr = m_head; e_maddr = m_slot;
                end
            end
            m_in_pkt = !last;
        end
        m_beats += inc_b; m_slots += inc_s;
        if (rv) begin
            m_beats = (rb > m_beats) ? 0 : m_beats - rb;
            m_slots = (m_slots == 0) ? 0 : m_slots - 1;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send_pkt(input int n, input logic [MW-1:0] u, input bit rel_on_last,
                            input int rb);
        for (int i = 0; i < n; i++) begin
            step(1'b1, i == n - 1, (i == 0) ? u : MW'($urandom),
                 rel_on_last && (i == n - 1), rb);
        end
    endtask

    task automatic do_reset();
        wr_en = 0; rel_valid = 0; tlast = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // 3-beat packet straight after reset.
        send_pkt(3, {{(MW - 8){1'b0}}, 8'hAB}, 1'b0, 0);
        chk("first_pkt_beats", 300'(beat_count), 300'(3));
        chk("first_pkt_slots", 300'(meta_count), 300'(1));

        // Fill to 2001 beats; a zero-beat release on each last beat keeps slots free.
        for (int p = 0; p < 41; p++) send_pkt(48, MW'($urandom), 1'b1, 0);
        send_pkt(30, MW'($urandom), 1'b1, 0);
        chk("fill_beats", 300'(beat_count), 300'(2001));
        chk("fill_af", 300'(data_af), 300'(1));
        send_pkt(3, MW'($urandom), 1'b0, 0);
        chk("drop_no_growth", 300'(beat_count), 300'(2001));
        step(1'b0, 1'b0, '0, 1'b1, 2001);

        // Wrap: move wr_ptr to 2046, then a 4-beat packet straddles the end of memory.
        send_pkt(45, MW'($urandom), 1'b0, 0);
        step(1'b0, 1'b0, '0, 1'b1, 45);
        send_pkt(4, MW'($urandom), 1'b0, 0);
        chk("wrap_head", 300'(pkt_addr), 300'(2046));

        // Metadata slots full: 32 one-beat packets, 33rd dropped, then one release.
        do_reset();
        for (int p = 0; p < 32; p++) send_pkt(1, MW'($urandom), 1'b0, 0);
        chk("meta_full", 300'(meta_af), 300'(1));
        send_pkt(1, MW'($urandom), 1'b0, 0);
        step(1'b0, 1'b0, '0, 1'b1, 1);
        send_pkt(1, MW'($urandom), 1'b0, 0);
        chk("slot_reuse", 300'(meta_addr), 300'(0));

        // Same-cycle write and release.
        do_reset();
        send_pkt(10, MW'($urandom), 1'b0, 0);
        send_pkt(1, MW'($urandom), 1'b1, 5);
        chk("net_count", 300'(beat_count), 300'(6));

        // Asynchronous reset during beat 2 of 4.
        do_reset();
        send_pkt(1, MW'($urandom), 1'b0, 0);
        step(1'b1, 1'b0, MW'($urandom), 1'b0, 0);
        wr_en = 1; tlast = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_mem_en", 300'(mem_wr_en), 300'(0));
        chk("async_rst_count", 300'(beat_count), 300'(0));
        @(posedge clk);
        #1;
        chk("rst_no_pulse", 300'(pkt_valid), 300'(0));
        wr_en = 0;
        reset = 1'b0;
        model_reset();
        send_pkt(2, MW'($urandom), 1'b0, 0);
        chk("post_rst_head", 300'(pkt_addr), 300'(0));
        chk("post_rst_slot", 300'(meta_addr), 300'(0));

        // Random packets, idle gaps and releases.
        for (int p = 0; p < 60; p++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                while ($urandom_range(0, 3) == 0) begin
                    step(1'b0, 1'b0, '0, $urandom_range(0, 4) == 0, $urandom_range(0, 12));
                end
                step(1'b1, i == n - 1, MW'($urandom), $urandom_range(0, 6) == 0,
                     $urandom_range(0, 12));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_buffer_writer.md
# pkt_buffer_writer

Per-port packet/metadata buffer write controller sitting directly downstream of the PIFO enqueue stage. It consumes the beat stream (data, keep, last, write enable) and the per-packet SUME metadata, admits or drops each whole packet, writes admitted beats into a ring-addressed packet memory and the metadata into a ring-addressed metadata memory, and returns the packet head address and metadata slot address used for PIFO rank entries. It also exports occupancy counts and almost-full flags that feed the enqueue stage's overflow checks.

## Interface
- DATA_WIDTH, 256, beat data width
- SUME_META_WIDTH, 128, metadata width
- PKT_ADDR_WIDTH, 11, packet memory beat address width (2048 beats)
- META_ADDR_WIDTH, 5, metadata slot address width (32 slots)
- MAX_PKT_BEATS, 48, worst-case beats per packet; admission/almost-full margin
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- s_axis_tdata  in  DATA_WIDTH  beat data
- s_axis_tkeep  in  DATA_WIDTH/8  byte enables
- s_axis_tlast  in  1  last beat of packet
- s_axis_tuser  in  SUME_META_WIDTH  metadata, valid on first beat
- s_axis_wr_en  in  1  beat present this cycle
- s_release_valid  in  1  packet reclaimed by dequeue side
- s_release_beats  in  PKT_ADDR_WIDTH  beats freed by that packet
- m_mem_wr_en  out  1  packet memory write strobe
- m_mem_wr_addr  out  PKT_ADDR_WIDTH  packet memory address
- m_mem_wr_data  out  1+DATA_WIDTH/8+DATA_WIDTH  {tlast, tkeep, tdata}
- m_meta_wr_en  out  1  metadata memory write strobe
- m_meta_wr_addr  out  META_ADDR_WIDTH  metadata slot
- m_meta_wr_data  out  SUME_META_WIDTH  metadata
- m_axis_packet_addr  out  PKT_ADDR_WIDTH  head beat address of completed packet
- m_axis_packet_addr_valid  out  1  one-cycle pulse
- m_axis_meta_addr  out  META_ADDR_WIDTH  slot of completed packet
- m_axis_meta_addr_valid  out  1  one-cycle pulse, coincident with packet pulse
- m_beat_count  out  PKT_ADDR_WIDTH+1  occupied beats
- m_meta_count  out  META_ADDR_WIDTH+1  occupied slots
- m_data_almost_full  out  1  free beats < MAX_PKT_BEATS
- m_meta_almost_full  out  1  free slots == 0
- m_drop_count  out  32  dropped packets (see Configuration)

## Operation
- FSM: IDLE, WRITE, DROP. Only beats with s_axis_wr_en=1 advance state.
- IDLE, first beat: admit iff free beats ≥ MAX_PKT_BEATS and free slots ≥ 1. Admit: latch head = wr_ptr, slot = meta_ptr; write metadata; write beat; go WRITE (or stay IDLE if tlast). Reject: write nothing; go DROP (or stay IDLE if tlast); drop counter +1.
- WRITE: write each beat at wr_ptr, wr_ptr+1 (mod 2^PKT_ADDR_WIDTH); on tlast return to IDLE and fire completion pulses with latched head/slot.
- DROP: discard beats; tlast returns to IDLE.
- Packets exceeding MAX_PKT_BEATS beats: remaining beats written anyway; caller guarantees the bound.
- m_beat_count += beats written, -= s_release_beats on release; same-cycle write and release apply net. m_meta_count +1 on admit, -1 on release, net when simultaneous.
- Release with beats > count or meta_count == 0: counters saturate at 0.
- Almost-full flags combinational from registered counters.

## Timing
- Memory writes registered: beat accepted at cycle N -> m_mem_wr_en at N+1; metadata write at N+1 of first beat.
- Completion pulses at N+1 of the tlast beat, same cycle as last memory write.
- Counters update at N+1; admission at cycle N uses counters as of N (release at N not yet visible).
- Reset (any time, including mid-packet): all outputs 0, pointers 0, counters 0, FSM IDLE; partial packet abandoned, no pulse.

## Configuration
- PKT_BUFFER_WRITER_DROP_CNT_EN defined: 32-bit wrapping drop counter drives m_drop_count.
- Undefined: no counter logic; m_drop_count tied to 0.

## Test plan
- Reset then 3-beat packet, tuser=0x..AB -> mem writes at addrs 0,1,2 on cycles +1..+3; meta slot 0; packet_addr=0, meta_addr=0 pulse with last write; beat_count=3, meta_count=1.
- Fill to 2001 beats (free 47), send packet -> no writes, no pulses, m_drop_count=1, FSM back to IDLE after tlast; data_almost_full=1.
- 32 one-beat packets, no release -> meta_almost_full=1; 33rd dropped; release 1 packet (1 beat) -> next admitted at slot 0.
- wr_ptr at 2046, 4-beat packet -> addrs 2046, 2047, 0, 1; packet_addr=2046.
- Same-cycle beat write and release of 5 beats with beat_count=10 -> beat_count=6.
- Assert reset during beat 2 of 4 -> outputs 0, no completion pulse; next packet starts at addr 0, slot 0.
